// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked, multi-cycle, big-endian byte memory serving MEM-stage loads/stores.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned MEM_BYTES = 1 << ADDR_W;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  logic               lat_we;
  logic [1:0]         lat_size;
  logic               lat_se;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;

  logic               eff_we;
  logic [1:0]         eff_size;
  logic               eff_se;
  logic [ADDR_W-1:0]  eff_addr;
  logic [DATA_W-1:0]  eff_wdata;

  logic [ADDR_W-1:0]  a0, a1, a2, a3;
  logic [7:0]         b0, b1, b2, b3;
  logic [DATA_W-1:0]  load_data;
  logic               mis_err;
  logic               enter_resp;
  logic               do_write;

  logic [7:0]         mem [MEM_BYTES];

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) state_d = S_RESP;
          else                  state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the accept edge is also the RESP-entry edge, so use the live request
  assign eff_we    = (state_q == S_IDLE) ? req_we    : lat_we;
  assign eff_size  = (state_q == S_IDLE) ? req_size  : lat_size;
  assign eff_se    = (state_q == S_IDLE) ? req_se    : lat_se;
  assign eff_addr  = (state_q == S_IDLE) ? req_addr  : lat_addr;
  assign eff_wdata = (state_q == S_IDLE) ? req_wdata : lat_wdata;

  // Force natural alignment; after this no access straddles the array end
  always_comb begin
    a0 = eff_addr;
    if (eff_size == 2'b01) a0[0]   = 1'b0;
    else if (eff_size[1])  a0[1:0] = 2'b00;
  end

  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

`ifdef MISALIGN_TRAP_EN
  assign mis_err = ((eff_size == 2'b01) && eff_addr[0]) ||
                   (eff_size[1] && (eff_addr[1:0] != 2'b00));
`else
  assign mis_err = 1'b0;
`endif

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // Big-endian assembly with optional sign extension for sub-word loads
  always_comb begin
    load_data = '0;
    case (eff_size)
      2'b00:   load_data = eff_se ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   load_data = eff_se ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      default: load_data = {b0, b1, b2, b3};
    endcase
  end

  assign enter_resp = (state_d == S_RESP);
  assign do_write   = !reset && enter_resp && eff_we && !mis_err;

  // Control state and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
      rsp_valid <= enter_resp;
      rsp_rdata <= (enter_resp && !eff_we && !mis_err) ? load_data : '0;
      rsp_err   <= enter_resp && mis_err;
    end
  end

  // Request capture at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_size  <= req_size;
      lat_se    <= req_se;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Store commit on the edge entering RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      case (eff_size)
        2'b00: mem[a0] <= eff_wdata[7:0];
        2'b01: begin
          mem[a0] <= eff_wdata[15:8];
          mem[a1] <= eff_wdata[7:0];
        end
        default: begin
          mem[a0] <= eff_wdata[31:24];
          mem[a1] <= eff_wdata[23:16];
          mem[a2] <= eff_wdata[15:8];
          mem[a3] <= eff_wdata[7:0];
        end
      endcase
    end
  end

endmodule
